// File: rtl/pack_fifo_pkg.sv
// Shared constants for the chunk-packing FIFO.
// Parameter defaults, derived widths and a safe clog2 helper.
package pack_fifo_pkg;

   localparam int DEF_DATA_IN_WIDTH  = 4;
   localparam int DEF_DATA_OUT_WIDTH = 16;
   localparam int DEF_DEPTH          = 4;

   // Guards against zero-width vectors when n <= 1.
   function automatic int clog2w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int RATIO       = DEF_DATA_OUT_WIDTH / DEF_DATA_IN_WIDTH;
   localparam int ADDR_WIDTH  = clog2w(DEF_DEPTH);
   localparam int CNT_WIDTH   = clog2w(RATIO);
   localparam int LEVEL_WIDTH = clog2w(DEF_DEPTH + 1);

endpackage

// File: rtl/pack_fifo_chunk_assembler.sv
// Collects narrow chunks into one wide word, chunk 0 least significant.
// Ports: clk, rst, i_valid/i_din (accepted chunk), o_word, o_word_valid.
module chunk_assembler
   import pack_fifo_pkg::*;
#(
   parameter int IN_W  = DEF_DATA_IN_WIDTH,
   parameter int OUT_W = DEF_DATA_OUT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [IN_W-1:0]  i_din,
   output logic [OUT_W-1:0] o_word,
   output logic             o_word_valid
);

   localparam int R  = OUT_W / IN_W;
   localparam int CW = clog2w(R);

   logic [CW-1:0]         r_cnt;
   logic [OUT_W-IN_W-1:0] r_asm;
   logic                  w_last;

   assign w_last = (r_cnt == CW'(R - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_asm <= '0;
      end else if (i_valid) begin
         if (w_last) r_cnt <= '0;
         else        r_cnt <= r_cnt + CW'(1);
         for (int k = 0; k < R - 1; k++) begin
            if (r_cnt == CW'(k)) r_asm[k*IN_W +: IN_W] <= i_din;
         end
      end
   end

   // The last chunk bypasses the register and commits straight away.
   assign o_word       = {i_din, r_asm};
   assign o_word_valid = i_valid & w_last;

endmodule

// File: rtl/pack_fifo.sv
// FIFO that packs narrow chunks into wide words before storing them.
// Ports: clk, rst, din, wr_en, rd_en, dout (registered), full, empty, level.
module pack_fifo
   import pack_fifo_pkg::*;
#(
   parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
   parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
   parameter int DEPTH          = DEF_DEPTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_IN_WIDTH-1:0]          din,
   input  logic                              wr_en,
   input  logic                              rd_en,
   output logic [DATA_OUT_WIDTH-1:0]         dout,
   output logic                              full,
   output logic                              empty,
   output logic [clog2w(DEPTH+1)-1:0]        level
);

   localparam int AW = clog2w(DEPTH);
   localparam int LW = clog2w(DEPTH + 1);

   logic [DATA_OUT_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]             r_wr_ptr;
   logic [AW-1:0]             r_rd_ptr;
   logic [LW-1:0]             r_level;
   logic                      r_full;
   logic                      r_empty;
   logic [DATA_OUT_WIDTH-1:0] r_dout;

   logic                      w_wr_acc;
   logic                      w_rd_acc;
   logic                      w_commit;
   logic [DATA_OUT_WIDTH-1:0] w_word;
   logic [LW-1:0]             w_lvl_nxt;

   // Full blocks every chunk, even when a read frees a slot this cycle.
   assign w_wr_acc = wr_en & ~r_full;
   assign w_rd_acc = rd_en & ~r_empty;

   chunk_assembler #(
      .IN_W  (DATA_IN_WIDTH),
      .OUT_W (DATA_OUT_WIDTH)
   ) u_asm (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (w_wr_acc),
      .i_din        (din),
      .o_word       (w_word),
      .o_word_valid (w_commit)
   );

   always_comb begin
      w_lvl_nxt = r_level;
      if (w_commit && !w_rd_acc)      w_lvl_nxt = r_level + LW'(1);
      else if (!w_commit && w_rd_acc) w_lvl_nxt = r_level - LW'(1);
   end

   // Storage carries no reset.
   always_ff @(posedge clk) begin
      if (!rst && w_commit) r_mem[r_wr_ptr] <= w_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_dout   <= '0;
      end else begin
         if (w_commit) begin
            if (r_wr_ptr == AW'(DEPTH - 1)) r_wr_ptr <= '0;
            else                            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_acc) begin
            r_dout <= r_mem[r_rd_ptr];
            if (r_rd_ptr == AW'(DEPTH - 1)) r_rd_ptr <= '0;
            else                            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level <= w_lvl_nxt;
         r_full  <= (w_lvl_nxt == LW'(DEPTH));
         r_empty <= (w_lvl_nxt == '0);
      end
   end

   assign dout  = r_dout;
   assign full  = r_full;
   assign empty = r_empty;
   assign level = r_level;

endmodule
